// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - opcode and FSM state constants shared by the register-file sequencer
// The CLR state only exists when REGFILE_SEQUENCER_CLEAR_EN is defined.
package regfile_pkg;

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_ADD   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_READ  = 3'd1;
   localparam logic [2:0] ST_WRITE = 3'd2;
`ifdef REGFILE_SEQUENCER_CLEAR_EN
   localparam logic [2:0] ST_CLR   = 3'd3;
`endif
   localparam logic [2:0] ST_RESP  = 3'd4;

endpackage

// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - one-command-at-a-time sequencer for an external 3-read/1-write register file
// Define REGFILE_SEQUENCER_CLEAR_EN to make CLEAR zero every register through the CLR state.
module regfile_sequencer
   import regfile_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              nRESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_dst,
   input  logic [ADDR_W-1:0] cmd_srcA,
   input  logic [ADDR_W-1:0] cmd_srcB,
   input  logic [DATA_W-1:0] cmd_imm,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              write_enable,
   output logic [ADDR_W-1:0] write_addr,
   output logic [DATA_W-1:0] write_data,
   output logic [ADDR_W-1:0] read_addr_A,
   output logic [ADDR_W-1:0] read_addr_B,
   output logic [ADDR_W-1:0] read_addr_C,
   input  logic [DATA_W-1:0] read_data_A,
   input  logic [DATA_W-1:0] read_data_B,
   input  logic [DATA_W-1:0] read_data_C
);

   logic [2:0]        state;
   logic [2:0]        state_nxt;
   logic [1:0]        op_q;
   logic [ADDR_W-1:0] dst_q;
   logic [ADDR_W-1:0] srca_q;
   logic [ADDR_W-1:0] srcb_q;
   logic [DATA_W-1:0] imm_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;

   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         state  <= ST_IDLE;
         op_q   <= OP_WRITE;
         dst_q  <= '0;
         srca_q <= '0;
         srcb_q <= '0;
         imm_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && cmd_valid) begin
            op_q   <= cmd_op;
            dst_q  <= cmd_dst;
            srca_q <= cmd_srcA;
            srcb_q <= cmd_srcB;
            imm_q  <= cmd_imm;
         end
         // Sources are sampled before any write-back, so dst may alias a source.
         if (state == ST_READ) begin
            a_q <= read_data_A;
            b_q <= read_data_B;
         end
      end
   end

`ifdef REGFILE_SEQUENCER_CLEAR_EN
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   logic [ADDR_W-1:0] clr_cnt;

   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         clr_cnt <= '0;
      end else if (state == ST_CLR) begin
         clr_cnt <= clr_cnt + ADDR_ONE;
      end
   end
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (cmd_valid) state_nxt = ST_READ;
         end
         ST_READ: begin
            case (op_q)
               OP_WRITE, OP_ADD: state_nxt = ST_WRITE;
`ifdef REGFILE_SEQUENCER_CLEAR_EN
               OP_CLEAR:         state_nxt = ST_CLR;
`else
               OP_CLEAR:         state_nxt = ST_RESP;
`endif
               default:          state_nxt = ST_RESP;
            endcase
         end
         ST_WRITE: state_nxt = ST_RESP;
`ifdef REGFILE_SEQUENCER_CLEAR_EN
         ST_CLR: begin
            if (clr_cnt == ADDR_LAST) state_nxt = ST_RESP;
         end
`endif
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready    = (state == ST_IDLE);
      rsp_valid    = 1'b0;
      rsp_data     = '0;
      write_enable = 1'b0;
      write_addr   = '0;
      write_data   = '0;
      read_addr_A  = '0;
      read_addr_B  = '0;
      read_addr_C  = '0;
      case (state)
         ST_READ: begin
            read_addr_A = srca_q;
            read_addr_B = srcb_q;
         end
         ST_WRITE: begin
            write_enable = 1'b1;
            write_addr   = dst_q;
            write_data   = (op_q == OP_ADD) ? a_q + b_q : imm_q;
         end
`ifdef REGFILE_SEQUENCER_CLEAR_EN
         ST_CLR: begin
            write_enable = 1'b1;
            write_addr   = clr_cnt;
         end
`endif
         ST_RESP: begin
            rsp_valid   = 1'b1;
            read_addr_C = dst_q;
            case (op_q)
               OP_WRITE, OP_ADD: rsp_data = read_data_C;
               OP_READ:          rsp_data = a_q;
               default:          rsp_data = '0;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb/tb_regfile_sequencer.sv - self-checking bench for regfile_sequencer with a behavioural register file
// Build with REGFILE_SEQUENCER_CLEAR_EN defined to exercise the clearing CLEAR variant.
module tb_regfile_sequencer;
   import regfile_pkg::*;

   logic        clk = 1'b0;
   logic        nRESET = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'b00;
   logic [2:0]  cmd_dst = '0;
   logic [2:0]  cmd_srcA = '0;
   logic [2:0]  cmd_srcB = '0;
   logic [15:0] cmd_imm = '0;
   logic        rsp_valid;
   logic [15:0] rsp_data;
   logic        write_enable;
   logic [2:0]  write_addr;
   logic [15:0] write_data;
   logic [2:0]  read_addr_A;
   logic [2:0]  read_addr_B;
   logic [2:0]  read_addr_C;
   logic [15:0] read_data_A;
   logic [15:0] read_data_B;
   logic [15:0] read_data_C;

   typedef struct {
      logic [15:0] data;
      int          lat;
      int          nw;
      logic [2:0]  dst;
   } rsp_t;

   typedef struct {
      logic [2:0]  addr;
      logic [15:0] data;
   } wr_t;

   rsp_t        exp_q[$];
   wr_t         wlog[$];
   logic [15:0] rf[8];
   logic [15:0] mdl[8];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   regfile_sequencer #(.DATA_W(16), .ADDR_W(3)) dut (
      .clk          (clk),
      .nRESET       (nRESET),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_dst      (cmd_dst),
      .cmd_srcA     (cmd_srcA),
      .cmd_srcB     (cmd_srcB),
      .cmd_imm      (cmd_imm),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .write_enable (write_enable),
      .write_addr   (write_addr),
      .write_data   (write_data),
      .read_addr_A  (read_addr_A),
      .read_addr_B  (read_addr_B),
      .read_addr_C  (read_addr_C),
      .read_data_A  (read_data_A),
      .read_data_B  (read_data_B),
      .read_data_C  (read_data_C)
   );

   assign read_data_A = rf[read_addr_A];
   assign read_data_B = rf[read_addr_B];
   assign read_data_C = rf[read_addr_C];

   always @(posedge clk) begin
      if (write_enable) begin
         rf[write_addr] <= write_data;
         wlog.push_back('{addr: write_addr, data: write_data});
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [2:0] dst, input logic [2:0] sa,
                        input logic [2:0] sb, input logic [15:0] imm);
      rsp_t e;
      rsp_t g;
      int   lat;
      e.dst = dst;
      case (op)
         OP_WRITE: begin e.data = imm; e.lat = 3; e.nw = 1; mdl[dst] = imm; end
         OP_ADD: begin
            e.data = mdl[sa] + mdl[sb];
            e.lat = 3; e.nw = 1; mdl[dst] = e.data;
         end
         OP_READ: begin e.data = mdl[sa]; e.lat = 2; e.nw = 0; end
         default: begin
`ifdef REGFILE_SEQUENCER_CLEAR_EN
            e.data = 16'h0; e.lat = 10; e.nw = 8;
            for (int i = 0; i < 8; i++) mdl[i] = 16'h0;
`else
            e.data = 16'h0; e.lat = 2; e.nw = 0;
`endif
         end
      endcase
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst;
      cmd_srcA = sa; cmd_srcB = sb; cmd_imm = imm;
      lat = 0;
      while (!cmd_ready && lat < 20) begin @(negedge clk); lat++; end
      check("cmd_ready_timeout", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      exp_q.push_back(e);
      wlog.delete();
      lat = 0;
      do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 30);
      check("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
      g = exp_q.pop_front();
      check("rsp_data", {16'd0, rsp_data}, {16'd0, g.data});
      check("latency", lat, g.lat);
      check("write_count", wlog.size(), g.nw);
      if (g.nw == 1 && wlog.size() == 1) begin
         check("write_addr", {29'd0, wlog[0].addr}, {29'd0, g.dst});
         check("write_data", {16'd0, wlog[0].data}, {16'd0, g.data});
      end
      if (g.nw == 8 && wlog.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            check("clr_addr", {29'd0, wlog[i].addr}, i);
            check("clr_data", {16'd0, wlog[i].data}, 32'd0);
         end
      end
      @(negedge clk);
      check("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin rf[i] = 16'h0; mdl[i] = 16'h0; end
      #12;
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
      check("rst_write_enable", {31'd0, write_enable}, 32'd0);
      check("rst_write_data", {16'd0, write_data}, 32'd0);
      check("rst_read_addr_A", {29'd0, read_addr_A}, 32'd0);
      @(negedge clk);
      nRESET = 1'b1;

      issue(OP_WRITE, 3'd0, 3'd0, 3'd0, 16'h0001);
      issue(OP_WRITE, 3'd1, 3'd0, 3'd0, 16'h0002);
      issue(OP_ADD,   3'd2, 3'd0, 3'd1, 16'h0000);
      check("rf2_after_add", {16'd0, rf[2]}, {16'd0, mdl[2]});
      issue(OP_READ,  3'd0, 3'd2, 3'd0, 16'h0000);
      issue(OP_WRITE, 3'd2, 3'd0, 3'd0, 16'hFFFF);
      issue(OP_ADD,   3'd2, 3'd2, 3'd2, 16'h0000);
      check("rf2_wrap", {16'd0, rf[2]}, 32'h0000FFFE);
      issue(OP_WRITE, 3'd5, 3'd0, 3'd0, 16'h1234);
      issue(OP_CLEAR, 3'd0, 3'd0, 3'd0, 16'h0000);
      issue(OP_READ,  3'd0, 3'd5, 3'd0, 16'h0000);
      issue(OP_READ,  3'd0, 3'd7, 3'd0, 16'h0000);

      // Abort a WRITE while write_enable is high.
      issue(OP_WRITE, 3'd3, 3'd0, 3'd0, 16'hAAAA);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_dst = 3'd3; cmd_imm = 16'h5555;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      check("abort_we_before", {31'd0, write_enable}, 32'd1);
      #1;
      nRESET = 1'b0;
      #1;
      check("abort_we_now", {31'd0, write_enable}, 32'd0);
      check("abort_ready", {31'd0, cmd_ready}, 32'd1);
      check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("abort_rf3", {16'd0, rf[3]}, {16'd0, mdl[3]});
      nRESET = 1'b1;
      @(negedge clk);
      check("abort_idle", {31'd0, cmd_ready}, 32'd1);
      issue(OP_READ, 3'd0, 3'd3, 3'd0, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_sequencer.md
REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register data width.
REQ-002 SHALL have parameter ADDR_W, default 3, register address width (8 registers).
REQ-003 SHALL have port clk  in  1  single clock, rising-edge.
REQ-004 SHALL have port nRESET  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid  in  1  command offered.
REQ-006 SHALL have port cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high at a clock edge.
REQ-007 SHALL have port cmd_op  in  2  operation: 00 WRITE, 01 READ, 10 ADD, 11 CLEAR.
REQ-008 SHALL have ports cmd_dst, cmd_srcA, cmd_srcB  in  ADDR_W each  destination and source register addresses.
REQ-009 SHALL have port cmd_imm  in  DATA_W  immediate value for WRITE.
REQ-010 SHALL have ports rsp_valid  out  1  and rsp_data  out  DATA_W  for the one-cycle result.
REQ-011 SHALL have ports write_enable  out  1, write_addr  out  ADDR_W, write_data  out  DATA_W  to the register file.
REQ-012 SHALL have ports read_addr_A, read_addr_B, read_addr_C  out  ADDR_W  to the register file.
REQ-013 SHALL have ports read_data_A, read_data_B, read_data_C  in  DATA_W from the register file, combinational from the read addresses.

Function
REQ-014 SHALL implement FSM states IDLE, READ, WRITE, CLR, RESP.
REQ-015 SHALL drive cmd_ready high only in IDLE.
REQ-016 SHALL latch cmd_op, addresses and immediate on acceptance, then leave IDLE for READ.
REQ-017 SHALL, in READ, drive read_addr_A=srcA and read_addr_B=srcB and capture read_data_A and read_data_B at the end of the cycle.
REQ-018 SHALL transition READ->WRITE for WRITE/ADD, READ->RESP for READ, READ->CLR for CLEAR (macro on) or READ->RESP (macro off).
REQ-019 SHALL assert write_enable for exactly one cycle in WRITE, with write_addr=dst and write_data=imm (WRITE) or captured A+B modulo 2^DATA_W, carry discarded (ADD).
REQ-020 SHALL, in RESP, assert rsp_valid for one cycle and drive read_addr_C=dst. rsp_data SHALL be read_data_C for WRITE/ADD (write-back readback), captured A for READ, and 0 for CLEAR. The FSM SHALL then return to IDLE.
REQ-021 SHALL give a latency from acceptance edge to rsp_valid of 3 cycles for WRITE/ADD and 2 cycles for READ.
REQ-022 SHALL hold write_enable low and rsp_valid low in every state not named above; read_addr_* SHALL be 0 when not in use.
REQ-023 SHALL handle dst equal to srcA or srcB in ADD using the pre-write values, because sources are captured in READ.
REQ-024 SHALL ignore cmd_valid outside IDLE and drop no accepted command.

Reset
REQ-025 SHALL, while nRESET is low, immediately force IDLE and drive cmd_ready=1 (once released), rsp_valid=0, rsp_data=0, write_enable=0, and all addresses, write_data and the clear counter to 0.
REQ-026 SHALL abort any in-flight command on reset mid-operation, with no partial write issued after reset assertion.

Configuration
REQ-027 SHALL, when macro REGFILE_SEQUENCER_CLEAR_EN is defined, use the CLR state to write 0 to addresses 0..2^ADDR_W-1 in consecutive cycles (write_enable high 8 cycles, counter increments then wraps to 0), then enter RESP.
REQ-028 SHALL, when REGFILE_SEQUENCER_CLEAR_EN is undefined, omit the CLR state and counter, and treat CLEAR as a NOP: no write, rsp_data=0, latency 2.

Structure
REQ-029 SHALL place the opcode constants (OP_WRITE, OP_READ, OP_ADD, OP_CLEAR) and the FSM state encoding in shared package regfile_pkg.
REQ-030 SHALL implement the design as a single module with no sub-module. The bench SHALL instantiate it against the existing register-file block.

Verification
REQ-031 SHALL cover: WRITE dst=0 imm=1, then dst=1 imm=2 -> each rsp_data equals the immediate, 3 cycles after acceptance.
REQ-032 SHALL cover: ADD srcA=0 srcB=1 dst=2 after REQ-031 -> register 2 equals 3 and rsp_data=3.
REQ-033 SHALL cover: ADD srcA=2 srcB=2 dst=2 with reg2=16'hFFFF -> result 16'hFFFE, carry discarded.
REQ-034 SHALL cover: READ srcA=2 -> rsp_data=3 at latency 2, write_enable never asserted.
REQ-035 SHALL cover: CLEAR with macro on -> 8 consecutive writes of 0 to addresses 0..7, then READ of any register returns 0. With macro off -> no write, rsp_data=0.
REQ-036 SHALL cover: nRESET pulled low during WRITE state -> write_enable drops low immediately, FSM in IDLE after release, target register unchanged.
